shift_serializer: RTL

Parametrised parallel-in/serial-out shifter with a one-word holding buffer, ready/load handshake, programmable bit period and selectable bit order. It is the successor to the fixed 8-bit load/shift register in the serial output path. It accepts a word while the previous one is still shifting, so consecutive words go out with no idle gap. It also reports busy/done/overrun status to the controlling logic.

---
 rtl/shift_serializer.sv | 119 +++++++++++
 1 files changed

// File: rtl/shift_serializer.sv
// Parallel-in/serial-out shifter with a one-word holding buffer so consecutive
// words leave back-to-back; reports busy/done/overrun status.
module shift_serializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int BIT_CYCLES = 1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             data_out,
  output logic             bit_strobe,
  output logic             busy,
  output logic             done,
  output logic             overrun
);

  localparam int BIT_W = $clog2(WIDTH);
  localparam int DIV_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
  localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(BIT_CYCLES - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   hold_q;
  logic [WIDTH-1:0]   shift_q;
  logic [BIT_W-1:0]   bit_cnt;
  logic [DIV_W-1:0]   div_cnt;

  // Bit presented on data_out for a given shift-register contents.
  function automatic logic head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  // ready doubles as the inverted hold_full flag; a load and a transfer can
  // never touch it on the same edge since they need opposite values of it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      hold_q     <= '0;
      shift_q    <= '0;
      bit_cnt    <= '0;
      div_cnt    <= '0;
      ready      <= 1'b1;
      data_out   <= IDLE_LEVEL;
      bit_strobe <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      bit_strobe <= 1'b0;
      done       <= 1'b0;

      if (load) begin
        if (ready) begin
          hold_q <= data_in;
          ready  <= 1'b0;
        end else begin
          overrun <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (!ready) begin
            shift_q    <= hold_q;
            data_out   <= head(hold_q);
            ready      <= 1'b1;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            bit_strobe <= 1'b1;
            busy       <= 1'b1;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          if (div_cnt != LAST_DIV) begin
            div_cnt <= div_cnt + DIV_W'(1);
          end else begin
            div_cnt <= '0;
            if (bit_cnt != LAST_BIT) begin
              shift_q    <= advance(shift_q);
              data_out   <= head(advance(shift_q));
              bit_cnt    <= bit_cnt + BIT_W'(1);
              bit_strobe <= 1'b1;
            end else begin
              done    <= 1'b1;
              bit_cnt <= '0;
              if (!ready) begin
                // Refilled in time: next word starts on this same edge.
                shift_q    <= hold_q;
                data_out   <= head(hold_q);
                ready      <= 1'b1;
                bit_strobe <= 1'b1;
              end else begin
                busy     <= 1'b0;
                data_out <= IDLE_LEVEL;
                state    <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
